// File: rtl/full_hash_des_pkg.sv
// Shared types, constants and helper functions for the byte-serial DES-S1 hash engine.
package full_hash_des_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {StIdle, StAbsorb, StFinal, StDone} state_t;

  // H[0] sits in the most significant nibble.
  localparam logic [31:0] IV = 32'h4B71DF03;

  // DES S1, entry k = row*16 + col stored at bits [255-4k -: 4].
  localparam logic [255:0] S1_TABLE = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D
  };

  function automatic nibble_t rotl4(nibble_t x, logic [1:0] n);
    logic [7:0] t;
    t = {x, x} << n;
    return t[7:4];
  endfunction

  function automatic logic [5:0] m6_of(logic [7:0] b);
    return {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
  endfunction

  function automatic nibble_t s1(logic [5:0] m6);
    logic [5:0] idx;
    idx = {m6[5], m6[0], m6[4:1]};
    return S1_TABLE[255 - 4 * int'(idx) -: 4];
  endfunction

endpackage

// File: rtl/hash_round_comb.sv
// Combinational compression of one byte into the 8-nibble chaining state (all ROUNDS rounds).
module hash_round_comb
  import full_hash_des_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic [31:0] i_h,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_h
);

  nibble_t w_s;
  nibble_t w_n [8];

  always_comb begin
    w_s = s1(m6_of(i_byte));
    for (int i = 0; i < 8; i++) w_n[i] = i_h[31 - 4 * i -: 4];
    // In-place update: H[7] deliberately sees the already-updated H[0].
    for (int r = 0; r < int'(ROUNDS); r++) begin
      for (int i = 0; i < 8; i++) begin
        w_n[i] = rotl4(w_n[(i + 1) % 8] ^ w_s, 2'(i >> 1));
      end
    end
    o_h = '0;
    for (int i = 0; i < 8; i++) o_h[31 - 4 * i -: 4] = w_n[i];
  end

endmodule

// File: rtl/full_hash_des.sv
// Byte-serial 32-bit hash: absorbs one byte per clock, then folds in the 64-bit length.
module full_hash_des
  import full_hash_des_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic [7:0]  M,
  input  logic [63:0] C_in,
  output logic        hash_ready,
  output logic [31:0] digest_final
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_h, w_h_nxt;
  logic [31:0] r_digest, w_digest_nxt;
  logic [63:0] r_cnt, w_cnt_nxt;
  logic [63:0] r_len, w_len_nxt;
  logic        r_ready, w_ready_nxt;

  logic             w_start;
  logic [63:0]      w_len_eff;
  logic [31:0]      w_abs_in, w_abs_out;
  logic [8:0][31:0] w_fin;

  assign w_start   = M_valid && (r_state == StIdle || r_state == StDone);
  assign w_abs_in  = w_start ? IV : r_h;
  assign w_len_eff = (C_in == '0) ? 64'd1 : C_in;

  hash_round_comb #(.ROUNDS(ROUNDS)) u_absorb (
    .i_h   (w_abs_in),
    .i_byte(M),
    .o_h   (w_abs_out)
  );

  // Length bytes are folded in MSB first, one chained stage per byte.
  assign w_fin[0] = r_h;
  for (genvar k = 0; k < 8; k++) begin : g_fin
    hash_round_comb #(.ROUNDS(ROUNDS)) u_fin (
      .i_h   (w_fin[k]),
      .i_byte(r_len[63 - 8 * k -: 8]),
      .o_h   (w_fin[k + 1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_h      <= IV;
      r_cnt    <= '0;
      r_len    <= '0;
      r_ready  <= 1'b0;
      r_digest <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_h      <= w_h_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_ready  <= w_ready_nxt;
      r_digest <= w_digest_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_h_nxt      = r_h;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_ready_nxt  = r_ready;
    w_digest_nxt = r_digest;
    unique case (r_state)
      StIdle, StDone: begin
        if (M_valid) begin
          w_h_nxt     = w_abs_out;
          w_cnt_nxt   = 64'd1;
          w_len_nxt   = w_len_eff;
          w_ready_nxt = 1'b0;
          w_state_nxt = (w_len_eff == 64'd1) ? StFinal : StAbsorb;
        end
      end
      StAbsorb: begin
        if (M_valid) begin
          w_h_nxt   = w_abs_out;
          w_cnt_nxt = r_cnt + 64'd1;
          if (r_cnt + 64'd1 == r_len) w_state_nxt = StFinal;
        end
      end
      StFinal: begin
        w_h_nxt      = w_fin[8];
        w_digest_nxt = w_fin[8];
        w_ready_nxt  = 1'b1;
        w_state_nxt  = StDone;
      end
    endcase
  end

  assign hash_ready   = r_ready;
  assign digest_final = r_digest;

endmodule

// File: tb/tb_full_hash_des.sv
// Self-checking bench: vector table with golden digests from an arithmetic reference model.
module tb_full_hash_des;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_valid = 1'b0;
  logic [7:0]  M = '0;
  logic [63:0] C_in = '0;
  logic        hash_ready;
  logic [31:0] digest_final;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  full_hash_des #(.ROUNDS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .M_valid     (M_valid),
    .M           (M),
    .C_in        (C_in),
    .hash_ready  (hash_ready),
    .digest_final(digest_final)
  );

  int s1tab [4][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
  };
  int iv [8] = '{4, 11, 7, 1, 13, 15, 0, 3};
  int mh [8];

  typedef struct {
    int          n;
    int          len;
    int          gap;
    bit          final_valid;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [NV];
  logic [7:0]  vdata [NV][32];
  logic [31:0] got [NV];
  string       txt = "Messaggio in chiaro di prova";

  function automatic int bit_of(int v, int k);
    return (v >> k) & 1;
  endfunction

  function automatic void model_compress(int b);
    int m6, row, col, s, x, sh;
    m6 = ((bit_of(b, 3) ^ bit_of(b, 2)) << 5) | (bit_of(b, 1) << 4) | (bit_of(b, 0) << 3)
       | (bit_of(b, 7) << 2) | (bit_of(b, 6) << 1) | (bit_of(b, 5) ^ bit_of(b, 4));
    row = bit_of(m6, 5) * 2 + bit_of(m6, 0);
    col = (m6 >> 1) & 15;
    s = s1tab[row][col];
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < 8; i++) begin
        x = mh[(i + 1) % 8] ^ s;
        sh = i / 2;
        mh[i] = ((x << sh) | (x >> (4 - sh))) & 15;
      end
    end
  endfunction

  function automatic logic [31:0] model_digest(int v);
    longint unsigned ln;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) mh[i] = iv[i];
    for (int i = 0; i < vt[v].n; i++) model_compress(int'(vdata[v][i]));
    ln = (vt[v].len == 0) ? 64'd1 : longint'(vt[v].len);
    for (int k = 7; k >= 0; k--) model_compress(int'((ln >> (8 * k)) & 64'hFF));
    d = '0;
    for (int i = 0; i < 8; i++) d = (d << 4) | 32'(mh[i]);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_ne(input string name, input logic [31:0] a, input logic [31:0] b);
    n_total++;
    if (a !== b) n_pass++;
    else $display("FAIL %s: got %h for both, expected them to differ", name, a);
  endtask

  task automatic run_vec(input int v, output logic [31:0] dig);
    for (int i = 0; i < vt[v].n; i++) begin
      M_valid = 1'b1;
      M = vdata[v][i];
      if (i == 0) C_in = 64'(vt[v].len);
      else C_in = {$urandom, $urandom};
      tick();
      M_valid = 1'b0;
      check($sformatf("busy v%0d b%0d", v, i), {31'b0, hash_ready}, 32'd0);
      if (i < vt[v].n - 1) repeat (vt[v].gap) tick();
    end
    if (vt[v].final_valid) begin
      M_valid = 1'b1;
      M = 8'($urandom);
    end
    tick();
    M_valid = 1'b0;
    check($sformatf("ready v%0d", v), {31'b0, hash_ready}, 32'd1);
    check($sformatf("digest v%0d", v), digest_final, vt[v].exp);
    dig = digest_final;
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      vt[v] = '{n: 0, len: 0, gap: 0, final_valid: 1'b0, exp: '0};
      for (int i = 0; i < 32; i++) vdata[v][i] = '0;
    end
    foreach (vt[v]) if (v == 0 || v == 1 || v == 6) begin
      vt[v].n = 28;
      vt[v].len = 28;
      for (int i = 0; i < 28; i++) vdata[v][i] = txt[i];
    end
    vt[1].gap = 1;
    vt[6].final_valid = 1'b1;
    vt[2].n = 1; vt[2].len = 1; vdata[2][0] = 8'h00;
    vt[3].n = 1; vt[3].len = 1; vdata[3][0] = 8'h01;
    vt[4].n = 3; vt[4].len = 3;
    vt[5].n = 4; vt[5].len = 4;
    vdata[4][0] = 8'hA5; vdata[4][1] = 8'h3C; vdata[4][2] = 8'h7E;
    vdata[5][0] = 8'hA5; vdata[5][1] = 8'h3C; vdata[5][2] = 8'h7E; vdata[5][3] = 8'h00;
    for (int v = 7; v < NV; v++) begin
      vt[v].n = int'($urandom_range(1, 20));
      vt[v].len = vt[v].n;
      vt[v].gap = int'($urandom_range(0, 2));
      vt[v].final_valid = 1'($urandom);
      for (int i = 0; i < vt[v].n; i++) vdata[v][i] = 8'($urandom);
    end
    for (int v = 0; v < NV; v++) vt[v].exp = model_digest(v);

    rst = 1'b1;
    tick();
    tick();
    check("reset ready", {31'b0, hash_ready}, 32'd0);
    check("reset digest", digest_final, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle ready", {31'b0, hash_ready}, 32'd0);
    check("idle digest", digest_final, 32'h0);

    for (int v = 0; v < NV; v++) run_vec(v, got[v]);

    check("gap vs no gap", got[1], vt[0].exp);
    check_ne("byte 00 vs 01", got[2], got[3]);
    check_ne("len 3 vs 4", got[4], got[5]);

    repeat (5) tick();
    check("done hold ready", {31'b0, hash_ready}, 32'd1);
    check("done hold digest", digest_final, vt[NV - 1].exp);

    // Abort partway through a message; rst also wins over a simultaneous M_valid.
    for (int i = 0; i < 10; i++) begin
      M_valid = 1'b1;
      M = vdata[0][i];
      C_in = 64'd28;
      tick();
    end
    rst = 1'b1;
    M = vdata[0][10];
    tick();
    rst = 1'b0;
    M_valid = 1'b0;
    check("abort ready", {31'b0, hash_ready}, 32'd0);
    check("abort digest", digest_final, 32'h0);
    run_vec(0, got[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
